period_meter: RTL and testbench
===============================

# period_meter

Measures the period, in CLK cycles, of a strobe train produced by the frequency divider and reports the recovered division ratio. It is the receive end of the divider's output: the divider turns N into a one-in-N strobe, and this block turns that strobe back into N. It adds a lock indication after repeated identical measurements and a timeout for a stalled strobe. It sits beside the divider in the clock-management area and feeds status and configuration-check logic.

## Interface
- WIDTH, 32, width of the period counter and of PERIOD.
- LOCK_COUNT, 3, number of consecutive identical periods required to assert LOCKED (≥1).
- TIMEOUT_CYCLES, 1024, cycles without a strobe before TIMEOUT asserts (2 ≤ value < 2^WIDTH).
- CLK  in  1  single clock; all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- ENABLE  in  1  measurement enable, synchronous.
- PULSE_IN  in  1  synchronous strobe; each sampled high cycle is one event.
- PERIOD  out  WIDTH  last measured event-to-event distance in cycles.
- VALID  out  1  one-cycle pulse: PERIOD updated this cycle.
- LOCKED  out  1  LOCK_COUNT consecutive equal periods seen.
- TIMEOUT  out  1  sticky: no event for TIMEOUT_CYCLES.

## Operation
- Reset (RESET=0, async): state IDLE, cnt=0, PERIOD=0, VALID=0, LOCKED=0, TIMEOUT=0, match count=0.
- States: IDLE, WAIT_FIRST, MEASURE.
- IDLE: ENABLE=0. cnt=0, VALID=0, LOCKED=0, TIMEOUT=0, PERIOD holds. ENABLE=1 -> WAIT_FIRST.
- WAIT_FIRST: on the first event, cnt<=1 -> MEASURE. No VALID. TIMEOUT is not evaluated here.
- MEASURE, no event: cnt<=cnt+1. If cnt==TIMEOUT_CYCLES: TIMEOUT<=1, LOCKED<=0, match count<=0 -> WAIT_FIRST.
- MEASURE, event: PERIOD<=cnt, VALID<=1, cnt<=1, TIMEOUT<=0.
  - If cnt equals the previous PERIOD, match count increments, saturating at LOCK_COUNT.
  - Otherwise match count<=1.
  - LOCKED<=1 when the updated match count is LOCK_COUNT; LOCKED<=0 otherwise.
- Back-to-back events (PULSE_IN held high) measure PERIOD=1.
- ENABLE=0 in any state -> IDLE on the next edge. An event in the same cycle is ignored.
- An event in the same cycle cnt reaches TIMEOUT_CYCLES: the event wins. PERIOD<=TIMEOUT_CYCLES, no timeout.
- cnt never exceeds TIMEOUT_CYCLES and never wraps.
- The first period after WAIT_FIRST never matches, because there is no valid previous period; match count<=1.

## Timing
- Event sampled at edge k -> PERIOD/VALID visible after edge k; VALID high for exactly one cycle.
- Events at edges k and k+N -> PERIOD=N after edge k+N.
- With LOCK_COUNT=L, LOCKED rises with the VALID of the L-th identical period, i.e. L+1 events after WAIT_FIRST.
- TIMEOUT rises TIMEOUT_CYCLES edges after the last event and stays high until the next valid measurement or ENABLE=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset release is synchronized by the top-level reset logic; the block assumes a clean deassertion.

## Structure
- Shared package clk_mgmt_pkg holds:
  - the state enum (IDLE, WAIT_FIRST, MEASURE);
  - the default WIDTH;
  - the default LOCK_COUNT and TIMEOUT_CYCLES constants, shared with the divider's configuration logic.
- Single module; no sub-module warranted. The counter, FSM and lock tracker are small and tightly coupled.

## Test plan
- Reset, ENABLE=1, strobe every 5 cycles (divider N=5), LOCK_COUNT=3 -> no VALID on the first event; then PERIOD=5 with VALID on each following event; LOCKED high on the 4th event.
- Lock at 5, then the strobe gap changes to 7 -> PERIOD=7 with VALID, LOCKED drops the same cycle; LOCKED returns after three consecutive 7s.
- PULSE_IN held high continuously -> PERIOD=1 every cycle; LOCKED after LOCK_COUNT+1 cycles.
- TIMEOUT_CYCLES=16, strobe stops -> TIMEOUT and LOCKED=0 exactly 16 edges after the last event; a restarted strobe gives no VALID on its first event, and TIMEOUT clears with the next VALID.
- ENABLE dropped mid-measurement for 5 cycles with an event in the drop cycle -> the event is ignored, LOCKED=0, PERIOD holds; re-enable restarts from WAIT_FIRST.
- RESET asserted asynchronously mid-period -> all outputs zero immediately, without waiting for a clock edge; measurement restarts cleanly after release.

Source files
------------

// File: rtl/clk_mgmt_pkg.sv
// clk_mgmt_pkg
// Shared types and defaults for the clock-management area: the period
// meter state encoding and the default divider/meter configuration
// constants that the divider's configuration logic also references.
package clk_mgmt_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } pm_state_t;

  localparam int PM_WIDTH          = 32;
  localparam int PM_LOCK_COUNT     = 3;
  localparam int PM_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/period_meter.sv
// period_meter
// Recovers the division ratio N from a one-in-N strobe by counting CLK
// cycles between sampled PULSE_IN events. Flags LOCKED after LOCK_COUNT
// consecutive identical periods and a sticky TIMEOUT when the strobe stalls.
//
// Ports:
//   CLK       in   clock, all logic on posedge
//   RESET     in   asynchronous active-low reset
//   ENABLE    in   synchronous measurement enable
//   PULSE_IN  in   synchronous strobe, each high cycle is one event
//   PERIOD    out  last measured event-to-event distance (WIDTH bits)
//   VALID     out  one-cycle pulse when PERIOD updates
//   LOCKED    out  LOCK_COUNT consecutive equal periods seen
//   TIMEOUT   out  sticky, no event for TIMEOUT_CYCLES
//
// state      | meaning
// IDLE       | disabled, counters and flags cleared, PERIOD holds
// WAIT_FIRST | enabled, waiting for the event that opens a measurement
// MEASURE    | counting cycles since the last event
module period_meter
  import clk_mgmt_pkg::*;
#(
  parameter int WIDTH          = PM_WIDTH,
  parameter int LOCK_COUNT     = PM_LOCK_COUNT,
  parameter int TIMEOUT_CYCLES = PM_TIMEOUT_CYCLES
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             PULSE_IN,
  output logic [WIDTH-1:0] PERIOD,
  output logic             VALID,
  output logic             LOCKED,
  output logic             TIMEOUT
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] TO_LIMIT = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [MW-1:0]    LC_LIMIT = MW'(LOCK_COUNT);

  pm_state_t        state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic             valid_nxt, locked_nxt, timeout_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  // Set while the current measurement is the first since WAIT_FIRST; the
  // held PERIOD is then stale and must not count as a match.
  logic             first_meas, first_nxt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      PERIOD     <= '0;
      VALID      <= 1'b0;
      LOCKED     <= 1'b0;
      TIMEOUT    <= 1'b0;
      match_cnt  <= '0;
      first_meas <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      PERIOD     <= period_nxt;
      VALID      <= valid_nxt;
      LOCKED     <= locked_nxt;
      TIMEOUT    <= timeout_nxt;
      match_cnt  <= match_nxt;
      first_meas <= first_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    period_nxt  = PERIOD;
    valid_nxt   = 1'b0;
    locked_nxt  = LOCKED;
    timeout_nxt = TIMEOUT;
    match_nxt   = match_cnt;
    first_nxt   = first_meas;

    if (!ENABLE) begin
      // Disable overrides everything, including a same-cycle event.
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      locked_nxt  = 1'b0;
      timeout_nxt = 1'b0;
      match_nxt   = '0;
      first_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (PULSE_IN) begin
            cnt_nxt   = WIDTH'(1);
            first_nxt = 1'b1;
            state_nxt = MEASURE;
          end
        end
        MEASURE: begin
          // An event on the timeout cycle wins over the timeout.
          if (PULSE_IN) begin
            period_nxt  = cnt;
            valid_nxt   = 1'b1;
            cnt_nxt     = WIDTH'(1);
            timeout_nxt = 1'b0;
            first_nxt   = 1'b0;
            if (!first_meas && (cnt == PERIOD)) begin
              match_nxt = (match_cnt == LC_LIMIT) ? match_cnt : match_cnt + 1'b1;
            end else begin
              match_nxt = MW'(1);
            end
            locked_nxt = (match_nxt == LC_LIMIT);
          end else if (cnt == TO_LIMIT) begin
            timeout_nxt = 1'b1;
            locked_nxt  = 1'b0;
            match_nxt   = '0;
            cnt_nxt     = '0;
            state_nxt   = WAIT_FIRST;
          end else begin
            cnt_nxt = cnt + WIDTH'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
// Directed stimulus for period_meter with LOCK_COUNT=3, TIMEOUT_CYCLES=16.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_period_meter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        PULSE_IN;
  logic [31:0] PERIOD;
  logic        VALID;
  logic        LOCKED;
  logic        TIMEOUT;

  int checks = 0;
  int errors = 0;

  period_meter #(
    .WIDTH(32),
    .LOCK_COUNT(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .PULSE_IN(PULSE_IN),
    .PERIOD(PERIOD),
    .VALID(VALID),
    .LOCKED(LOCKED),
    .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic p);
    PULSE_IN = p;
    @(posedge CLK);
    #1;
  endtask

  // n-1 quiet edges then an event edge; VALID must stay low while quiet.
  task automatic gap(input int n);
    for (int i = 1; i < n; i++) begin
      step(1'b0);
      check("gap_valid", 32'(VALID), 0);
    end
    step(1'b1);
  endtask

  task automatic expect_meas(input string tag, input int per, input logic lk);
    check({tag, "_valid"}, 32'(VALID), 1);
    check({tag, "_period"}, PERIOD, per);
    check({tag, "_locked"}, 32'(LOCKED), 32'(lk));
    check({tag, "_timeout"}, 32'(TIMEOUT), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; ENABLE = 1'b0; PULSE_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_period", PERIOD, 0);
    check("rst_valid", 32'(VALID), 0);
    check("rst_locked", 32'(LOCKED), 0);
    check("rst_timeout", 32'(TIMEOUT), 0);
    RESET = 1'b1;
    ENABLE = 1'b1;

    // Divider N=5: lock on the 4th event.
    step(1'b0);                      // IDLE -> WAIT_FIRST
    step(1'b1);                      // first event
    check("first_valid", 32'(VALID), 0);
    check("first_period", PERIOD, 0);
    gap(5); expect_meas("n5_a", 5, 1'b0);
    gap(5); expect_meas("n5_b", 5, 1'b0);
    gap(5); expect_meas("n5_c", 5, 1'b1);
    step(1'b0);
    check("valid_one_cycle", 32'(VALID), 0);
    gap(4); expect_meas("n5_d", 5, 1'b1);

    // Ratio change to 7: lock drops, returns after three 7s.
    gap(7); expect_meas("n7_a", 7, 1'b0);
    gap(7); expect_meas("n7_b", 7, 1'b0);
    gap(7); expect_meas("n7_c", 7, 1'b1);

    // Strobe stops: timeout exactly 16 edges after the last event.
    for (int i = 1; i < 16; i++) begin
      step(1'b0);
      check("pre_to_timeout", 32'(TIMEOUT), 0);
      check("pre_to_locked", 32'(LOCKED), 1);
    end
    step(1'b0);
    check("to_timeout", 32'(TIMEOUT), 1);
    check("to_locked", 32'(LOCKED), 0);
    repeat (20) step(1'b0);
    check("to_sticky", 32'(TIMEOUT), 1);

    // Restart with PULSE_IN held high: first event no VALID, then PERIOD=1.
    step(1'b1);
    check("restart_valid", 32'(VALID), 0);
    check("restart_timeout", 32'(TIMEOUT), 1);
    step(1'b1); expect_meas("hold_a", 1, 1'b0);
    step(1'b1); expect_meas("hold_b", 1, 1'b0);
    step(1'b1); expect_meas("hold_c", 1, 1'b1);
    step(1'b1); expect_meas("hold_d", 1, 1'b1);

    // Event on the same cycle cnt reaches the limit: event wins.
    for (int i = 1; i < 16; i++) begin
      step(1'b0);
      check("edge_no_timeout", 32'(TIMEOUT), 0);
    end
    step(1'b1); expect_meas("edge16_a", 16, 1'b0);
    gap(16);    expect_meas("edge16_b", 16, 1'b0);
    gap(16);    expect_meas("edge16_c", 16, 1'b1);

    // ENABLE dropped mid-measurement with an event in the drop cycle.
    step(1'b0);
    step(1'b0);
    ENABLE = 1'b0;
    step(1'b1);
    check("dis_valid", 32'(VALID), 0);
    check("dis_locked", 32'(LOCKED), 0);
    check("dis_period", PERIOD, 16);
    for (int i = 0; i < 4; i++) begin
      step(i[0]);
      check("dis_hold_valid", 32'(VALID), 0);
      check("dis_hold_period", PERIOD, 16);
    end
    ENABLE = 1'b1;
    step(1'b1);                      // IDLE -> WAIT_FIRST, event ignored
    check("reen_idle_valid", 32'(VALID), 0);
    step(1'b1);                      // first event after re-enable
    check("reen_first_valid", 32'(VALID), 0);
    gap(3); expect_meas("reen_n3", 3, 1'b0);

    // Asynchronous reset mid-period.
    step(1'b0);
    #2;
    RESET = 1'b0;
    #1;
    check("arst_period", PERIOD, 0);
    check("arst_valid", 32'(VALID), 0);
    check("arst_locked", 32'(LOCKED), 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    step(1'b0);                      // IDLE -> WAIT_FIRST
    step(1'b1);
    check("post_rst_first", 32'(VALID), 0);
    gap(4); expect_meas("post_rst_n4", 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
